// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between a CPU port and a video scan-out port.
// Every access is an address cycle followed by a data cycle; video wins ties until its burst budget runs out.
module mem_arbiter #(
  parameter int unsigned VID_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        vid_req,
  input  logic [31:0] vid_adr,
  output logic [31:0] vid_rdata,
  output logic        vid_valid,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(VID_BURST + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CPU_A = 3'd1;
  localparam logic [2:0] CPU_D = 3'd2;
  localparam logic [2:0] VID_A = 3'd3;
  localparam logic [2:0] VID_D = 3'd4;

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] vid_cnt;
  logic             vid_cnt_full;
  logic [31:0]      cpu_rdata_q, vid_rdata_q;

  assign vid_cnt_full = (vid_cnt == CNT_W'(VID_BURST));

  // A finishing requester never gets the next slot if the other side is waiting.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (vid_req && !(cpu_req && vid_cnt_full)) state_nx = VID_A;
        else if (cpu_req)                          state_nx = CPU_A;
        else                                       state_nx = IDLE;
      end
      CPU_A:   state_nx = CPU_D;
      CPU_D:   state_nx = vid_req ? VID_A : IDLE;
      VID_A:   state_nx = VID_D;
      VID_D:   state_nx = cpu_req ? CPU_A : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      vid_cnt     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state <= state_nx;
      // VID_A and CPU_A are only ever entered from another state, so this is entry detection.
      if (state_nx == VID_A) begin
        if (!vid_cnt_full) vid_cnt <= vid_cnt + CNT_W'(1);
      end else if (state_nx == CPU_A) begin
        vid_cnt <= '0;
      end
      if (state == CPU_D) cpu_rdata_q <= mem_rdata;
      if (state == VID_D) vid_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    mem_adr   = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    vid_valid = 1'b0;
    cpu_rdata = cpu_rdata_q;
    vid_rdata = vid_rdata_q;
    case (state)
      CPU_A: begin
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      CPU_D: begin
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
        cpu_ready = 1'b1;
        cpu_rdata = mem_rdata;
      end
      VID_A: mem_adr = vid_adr;
      VID_D: begin
        mem_adr   = vid_adr;
        vid_valid = 1'b1;
        vid_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        vid_req;
  logic [31:0] vid_adr, vid_rdata;
  logic        vid_valid;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] ram [0:255];
  logic        pl_en;
  logic [7:0]  pl_adr;
  logic [31:0] pl_dat;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.VID_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en)       ram[pl_adr]       <= pl_dat;
    else if (mem_we) ram[mem_adr[9:2]] <= mem_wdata;
    mem_rdata <= ram[mem_adr[9:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_adr = a; pl_dat = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [33:0] exp_sig [0:3];
  int nv, nr, rdy_at, rdy_cyc, cyc;

  initial begin
    reset = 1'b0; cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wdata = 0;
    vid_req = 0; vid_adr = 0; pl_en = 0; pl_adr = 0; pl_dat = 0;
    exp_sig[0] = {2'b00, 32'h80}; exp_sig[1] = {2'b01, 32'h80};
    exp_sig[2] = {2'b00, 32'h44}; exp_sig[3] = {2'b10, 32'h44};

    #2;
    check("rst_adr", mem_adr, 0);
    check("rst_wd", mem_wdata, 0);
    check("rst_ctl", {cpu_ready, vid_valid, mem_we}, 0);
    check("rst_rdata", {cpu_rdata, vid_rdata}, 0);

    preload(8'h11, 32'h12345678);
    preload(8'h20, 32'hA5A50001);
    preload(8'h12, 32'h11111111);
    preload(8'h10, 32'h0);
    preload(8'h00, 32'h0);
    reset = 1'b1;

    // idle
    repeat (10) begin
      tick();
      check("idle", {mem_adr, mem_we, cpu_ready, vid_valid}, 0);
    end

    // cpu write
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    tick();
    check("wr_a_we", mem_we, 1);
    check("wr_a_adr", mem_adr, 32'h40);
    check("wr_a_wd", mem_wdata, 32'hDEADBEEF);
    check("wr_a_rdy", cpu_ready, 0);
    tick();
    check("wr_d", {cpu_ready, mem_we}, 2'b10);
    cpu_req = 0; cpu_we = 0;
    tick();
    check("wr_idle", {cpu_ready, mem_we}, 0);
    check("wr_ram", ram[8'h10], 32'hDEADBEEF);

    // cpu read, request withdrawn during the address cycle
    cpu_req = 1; cpu_adr = 32'h44;
    tick();
    check("rd_a", {mem_we, mem_adr}, {1'b0, 32'h44});
    cpu_req = 0;
    tick();
    check("rd_rdy", cpu_ready, 1);
    check("rd_data", cpu_rdata, 32'h12345678);
    tick();
    check("rd_hold", {cpu_ready, cpu_rdata}, {1'b0, 32'h12345678});

    // single video read
    vid_req = 1; vid_adr = 32'h80;
    tick();
    check("vid_a", {vid_valid, mem_we, mem_adr}, {2'b00, 32'h80});
    check("vid_a_wd", mem_wdata, 0);
    tick();
    check("vid_d", vid_valid, 1);
    check("vid_data", vid_rdata, 32'hA5A50001);
    vid_req = 0;
    tick();
    check("vid_hold", {vid_valid, vid_rdata}, {1'b0, 32'hA5A50001});

    // both held: strict alternation starting with video
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'h44; vid_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("contend%0d", i), {cpu_ready, vid_valid, mem_adr}, exp_sig[i % 4]);
    end
    cpu_req = 0; vid_req = 0;
    tick();

    // six video reads, cpu arrives with the first
    cpu_req = 1; cpu_adr = 32'h40; vid_req = 1;
    nv = 0; nr = 0; rdy_at = -1; rdy_cyc = -1; cyc = 0;
    while (nv < 6 && cyc < 60) begin
      tick(); cyc++;
      if (vid_valid) nv++;
      if (cpu_ready) begin nr++; rdy_at = nv; rdy_cyc = cyc; cpu_req = 0; end
      if (nv == 6) vid_req = 0;
    end
    vid_req = 0; cpu_req = 0;
    check("starve_nv", nv, 6);
    check("starve_nr", nr, 1);
    check("starve_at", rdy_at, 1);
    check("starve_cyc", rdy_cyc, 4);
    tick();

    // clear the burst count with a lone cpu access
    cpu_req = 1; cpu_adr = 32'h44;
    tick(); cpu_req = 0;
    tick(); tick();

    // four video grants, then cpu arriving in IDLE must win
    vid_req = 1; nv = 0; cyc = 0;
    while (nv < 4 && cyc < 40) begin
      tick(); cyc++;
      if (vid_valid) nv++;
    end
    check("burst_nv", nv, 4);
    tick();
    check("burst_idle", {mem_adr, vid_valid}, 0);
    cpu_req = 1; cpu_adr = 32'h40;
    tick();
    check("guard_cpu_a", {vid_valid, mem_adr}, {1'b0, 32'h40});
    tick();
    check("guard_rdy", {cpu_ready, cpu_rdata}, {1'b1, 32'hDEADBEEF});
    cpu_req = 0; vid_req = 0;
    tick();

    // reset during a cpu write address cycle
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h48; cpu_wdata = 32'hCAFEF00D;
    tick();
    check("rw_a_we", mem_we, 1);
    #1 reset = 1'b0;
    #1;
    check("rst_we", mem_we, 0);
    check("rst_adr2", mem_adr, 0);
    check("rst_wd2", mem_wdata, 0);
    check("rst_rdata2", {cpu_rdata, vid_rdata}, 0);
    check("rst_pulse", {cpu_ready, vid_valid}, 0);
    cpu_req = 0; cpu_we = 0;
    tick();
    check("rst_nordy", cpu_ready, 0);
    check("rst_noram", ram[8'h12], 32'h11111111);
    reset = 1'b1;

    // saturate the burst count, reset in VID_A, then video must win again
    vid_req = 1; vid_adr = 32'h80; nv = 0; cyc = 0;
    while (nv < 4 && cyc < 40) begin
      tick(); cyc++;
      if (vid_valid) nv++;
    end
    tick();
    tick();
    check("sat_vid_a", mem_adr, 32'h80);
    #1 reset = 1'b0;
    #1;
    check("rst_vid", {vid_valid, mem_adr}, 0);
    tick();
    check("rst_novalid", vid_valid, 0);
    cpu_req = 1; cpu_adr = 32'h44;
    reset = 1'b1;
    tick();
    check("post_rst_grant", mem_adr, 32'h80);
    tick();
    check("post_rst_valid", {vid_valid, vid_rdata}, {1'b1, 32'hA5A50001});
    vid_req = 0;
    tick();
    check("post_rst_cpu_a", mem_adr, 32'h44);
    tick();
    check("post_rst_rdy", {cpu_ready, cpu_rdata}, {1'b1, 32'h12345678});
    cpu_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: VID_BURST, default 4, the maximum number of consecutive video grants while the CPU is waiting.
REQ-002 The block SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, in, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port cpu_req, in, 1, CPU access request; held high with stable address and data until cpu_ready.
REQ-005 The block SHALL have port cpu_we, in, 1, CPU write enable qualifying cpu_req.
REQ-006 The block SHALL have ports cpu_adr and cpu_wdata, in, 32 each, CPU byte address and store data.
REQ-007 The block SHALL have ports cpu_rdata, out, 32, CPU load data, and cpu_ready, out, 1, a one-cycle completion pulse.
REQ-008 The block SHALL have ports vid_req, in, 1, and vid_adr, in, 32, the frame-buffer scan-out read request and address, held until vid_valid.
REQ-009 The block SHALL have ports vid_rdata, out, 32, and vid_valid, out, 1, video read data and a one-cycle valid pulse.
REQ-010 The block SHALL have ports mem_adr and mem_wdata, out, 32 each; mem_we, out, 1; and mem_rdata, in, 32; the single-port synchronous RAM (read data one cycle after address).

Function
REQ-011 The FSM SHALL have states IDLE, CPU_A, CPU_D, VID_A and VID_D; every access SHALL be an address cycle (*_A) followed by a data cycle (*_D).
REQ-012 Arbitration SHALL be performed in IDLE, CPU_D and VID_D.
REQ-013 In IDLE, vid_req SHALL win unless cpu_req=1 and vid_cnt==VID_BURST, in which case CPU wins; with only one request pending, that requester SHALL win; with none, the FSM SHALL stay in IDLE.
REQ-014 In CPU_D, a pending vid_req SHALL go to VID_A, otherwise to IDLE; the CPU's still-high cpu_req SHALL NOT be re-granted.
REQ-015 In VID_D, a pending cpu_req SHALL go to CPU_A, otherwise to IDLE.
REQ-016 vid_cnt SHALL increment, saturating at VID_BURST, on every entry to VID_A, and SHALL clear on every entry to CPU_A.
REQ-017 In CPU_A and CPU_D, mem_adr=cpu_adr and mem_wdata=cpu_wdata; in VID_A and VID_D, mem_adr=vid_adr; in IDLE, mem_adr=0; mem_wdata SHALL be 0 outside CPU states.
REQ-018 mem_we SHALL be 1 only in CPU_A with cpu_we=1; it SHALL never assert in any other state.
REQ-019 cpu_ready SHALL be 1 exactly in CPU_D, for reads and writes; vid_valid SHALL be 1 exactly in VID_D.
REQ-020 During CPU_D, cpu_rdata SHALL equal mem_rdata; a register SHALL capture that value at the end of CPU_D and hold it until the next CPU_D; vid_rdata SHALL behave the same for VID_D.
REQ-021 Minimum latency SHALL be: request seen in IDLE at cycle N -> *_A in N+1 -> ready/valid in N+2.
REQ-022 Once granted, an access SHALL complete through *_D even if its request drops during *_A.
REQ-023 Simultaneous requests with vid_cnt<VID_BURST SHALL grant video; the CPU SHALL then be granted within at most VID_BURST video accesses.

Reset
REQ-024 While reset=0, the block SHALL force state IDLE, vid_cnt=0, and cpu_rdata, vid_rdata, mem_adr and mem_wdata to 0, with cpu_ready, vid_valid and mem_we at 0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-access SHALL abort the access without completion pulse or write; after release, the first grant SHALL follow REQ-013.

Verification
REQ-026 CPU write only: cpu_req=1, cpu_we=1, cpu_adr=0x40, cpu_wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle with mem_adr=0x40; cpu_ready 2 cycles after request.
REQ-027 CPU read: RAM[0x44]=0x12345678, cpu_req=1, cpu_we=0 -> cpu_ready with cpu_rdata=0x12345678, value held after ready; mem_we stays 0.
REQ-028 Contention: vid_req and cpu_req held high continuously, VID_BURST=4 -> grant order VID,CPU,VID,CPU...; vid_cnt never exceeds 1; no access is lost.
REQ-029 Starvation guard: video issues 6 back-to-back reads, CPU requests at the first -> CPU granted after the first video access (from VID_D per REQ-015); with a CPU arriving in IDLE after 4 video grants, CPU wins over vid_req.
REQ-030 Reset mid-write: assert reset during CPU_A -> mem_we falls immediately, no cpu_ready, state IDLE, all outputs 0.
REQ-031 Idle: no requests for 10 cycles -> mem_adr=0, mem_we=0, no ready or valid pulses.
